// File: rtl/neopix_pkg.sv
// Shared types for the NeoPixel frame sequencer: pixel colour struct, FSM states, brightness helper.
package neopix_pkg;

  localparam int NEO_MAX_PIXELS = 8;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pixel_t;

  typedef enum logic [2:0] {IDLE, LOAD, ARM, SEND, DONE} seq_state_t;

  // Logical right shift of every channel; used only when brightness scaling is built in.
  function automatic pixel_t pixel_dim(input pixel_t p, input logic [1:0] shift);
    pixel_t q;
    q.red   = p.red   >> shift;
    q.green = p.green >> shift;
    q.blue  = p.blue  >> shift;
    return q;
  endfunction

endpackage

// File: rtl/neopix_if.sv
// Game-side write/request port plus controller load/go port of the frame sequencer.
// NEO_BRIGHTNESS_EN adds the bright_shift input.
interface neopix_if;
  logic       wr_en;
  logic [2:0] wr_pixel;
  logic [7:0] wr_red, wr_green, wr_blue;
  logic       frame_req;
  logic       nc_ready;
  logic       nc_load, nc_go;
  logic [2:0] nc_pixel;
  logic [7:0] nc_red, nc_green, nc_blue;
  logic       busy, frame_done;
`ifdef NEO_BRIGHTNESS_EN
  logic [1:0] bright_shift;
`endif

  modport master (
`ifdef NEO_BRIGHTNESS_EN
    input  bright_shift,
`endif
    input  wr_en, wr_pixel, wr_red, wr_green, wr_blue, frame_req, nc_ready,
    output nc_load, nc_go, nc_pixel, nc_red, nc_green, nc_blue, busy, frame_done
  );

  modport slave (
`ifdef NEO_BRIGHTNESS_EN
    output bright_shift,
`endif
    output wr_en, wr_pixel, wr_red, wr_green, wr_blue, frame_req, nc_ready,
    input  nc_load, nc_go, nc_pixel, nc_red, nc_green, nc_blue, busy, frame_done
  );
endinterface

// File: rtl/neopix_pixel_buffer.sv
// Shadow frame buffer: one write port, one asynchronous read port (read-before-write), cleared on reset.
module neopix_pixel_buffer
  import neopix_pkg::*;
#(
  parameter int NUM_PIXELS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_idx,
  input  pixel_t     wr_data,
  input  logic [2:0] rd_idx,
  output pixel_t     rd_data
);

  // Sized to the full 3-bit index range; entries past NUM_PIXELS are never written and stay 0.
  pixel_t mem [NEO_MAX_PIXELS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NEO_MAX_PIXELS; i++) mem[i] <= '0;
    end else if (wr_en && (int'(wr_idx) < NUM_PIXELS)) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/neopix_frame_sequencer.sv
// Streams the shadow frame buffer into the NeoPixel controller on refresh tick or request.
// NEO_BRIGHTNESS_EN: per-frame right-shift of all colour channels by bright_shift.
module neopix_frame_sequencer
  import neopix_pkg::*;
#(
  parameter int NUM_PIXELS     = 8,
  parameter int REFRESH_CYCLES = 833_333
) (
  input  logic     CLOCK_50,
  input  logic     reset,
  neopix_if.master bus
);

  localparam int               TMR_W    = $clog2(REFRESH_CYCLES);
  localparam logic [2:0]       LAST_IDX = 3'(NUM_PIXELS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CYCLES - 1);

  seq_state_t       state, state_n;
  logic [2:0]       idx, idx_n;
  logic             seen_low, seen_low_n;
  logic             pending;
  logic [TMR_W-1:0] timer;
  logic             wrap;
  logic             start, issue_load, issue_go, issue_done;
  pixel_t           wr_pix, rd_pix, drv_pix;

  assign wr_pix = '{red: bus.wr_red, green: bus.wr_green, blue: bus.wr_blue};

  neopix_pixel_buffer #(.NUM_PIXELS(NUM_PIXELS)) u_buf (
    .clk     (CLOCK_50),
    .rst     (reset),
    .wr_en   (bus.wr_en),
    .wr_idx  (bus.wr_pixel),
    .wr_data (wr_pix),
    .rd_idx  (idx),
    .rd_data (rd_pix)
  );

`ifdef NEO_BRIGHTNESS_EN
  logic [1:0] shift_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)      shift_q <= '0;
    else if (start) shift_q <= bus.bright_shift;
  end

  assign drv_pix = pixel_dim(rd_pix, shift_q);
`else
  assign drv_pix = rd_pix;
`endif

  assign wrap = (timer == TMR_LAST);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      seen_low <= 1'b0;
      pending  <= 1'b0;
      timer    <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      seen_low <= seen_low_n;
      // A request landing in the same cycle the frame starts is kept for the next frame.
      pending  <= (pending & ~start) | bus.frame_req | wrap;
      timer    <= wrap ? '0 : timer + 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    seen_low_n = seen_low;
    start      = 1'b0;
    issue_load = 1'b0;
    issue_go   = 1'b0;
    issue_done = 1'b0;
    case (state)
      IDLE: if (pending && bus.nc_ready) begin
        state_n = LOAD;
        idx_n   = '0;
        start   = 1'b1;
      end
      LOAD: if (bus.nc_ready) begin
        issue_load = 1'b1;
        if (idx == LAST_IDX) state_n = ARM;
        else                 idx_n   = idx + 3'd1;
      end
      ARM: if (bus.nc_ready) begin
        issue_go   = 1'b1;
        seen_low_n = 1'b0;
        state_n    = SEND;
      end
      // Transmission is over only after ready has dropped and come back.
      SEND: begin
        if (!bus.nc_ready)  seen_low_n = 1'b1;
        else if (seen_low)  state_n    = DONE;
      end
      DONE: begin
        issue_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      bus.nc_load    <= 1'b0;
      bus.nc_go      <= 1'b0;
      bus.nc_pixel   <= '0;
      bus.nc_red     <= '0;
      bus.nc_green   <= '0;
      bus.nc_blue    <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.nc_load    <= issue_load;
      bus.nc_go      <= issue_go;
      bus.frame_done <= issue_done;
      bus.busy       <= (state_n != IDLE);
      if (issue_load) begin
        bus.nc_pixel <= idx;
        bus.nc_red   <= drv_pix.red;
        bus.nc_green <= drv_pix.green;
        bus.nc_blue  <= drv_pix.blue;
      end
    end
  end

endmodule

// File: tb/tb_neopix_frame_sequencer.sv
// Directed + randomized bench for neopix_frame_sequencer against a shadow-buffer reference model.
// Build with NEO_BRIGHTNESS_EN defined to also exercise brightness scaling.
module tb_neopix_frame_sequencer;

  localparam int NPIX = 6;
  localparam int RCYC = 200;

  logic CLOCK_50 = 1'b0;
  logic reset;

  neopix_if bus();

  neopix_frame_sequencer #(.NUM_PIXELS(NPIX), .REFRESH_CYCLES(RCYC)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int         pix;
    logic [7:0] r, g, b;
    int         c;
  } ld_t;

  ld_t        ld_q[$];
  int         checks = 0, failures = 0, cyc = 0;
  int         go_cnt, go_cyc, done_cnt, done_cyc, busy_low, shv = 0, rst_cyc, rc, d;
  logic [7:0] mdl_r[8], mdl_g[8], mdl_b[8];
  logic [7:0] exp_r[8], exp_g[8], exp_b[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: advance, then sample every output 1 time unit after the edge.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    cyc++;
    if (bus.nc_load)
      ld_q.push_back('{int'(bus.nc_pixel), bus.nc_red, bus.nc_green, bus.nc_blue, cyc});
    if (bus.nc_go) begin go_cnt++; go_cyc = cyc; end
    if (bus.frame_done) begin done_cnt++; done_cyc = cyc; end
    if (ld_q.size() > 0 && done_cnt == 0 && !bus.busy) busy_low++;
  endtask

  task automatic clear_frame();
    ld_q.delete();
    go_cnt = 0; go_cyc = 0; done_cnt = 0; done_cyc = 0; busy_low = 0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin mdl_r[i] = 0; mdl_g[i] = 0; mdl_b[i] = 0; end
  endtask

  task automatic snap();
    for (int i = 0; i < 8; i++) begin exp_r[i] = mdl_r[i]; exp_g[i] = mdl_g[i]; exp_b[i] = mdl_b[i]; end
  endtask

  task automatic write_px(input int idx, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus.wr_en = 1'b1; bus.wr_pixel = 3'(idx);
    bus.wr_red = r; bus.wr_green = g; bus.wr_blue = b;
    tick();
    bus.wr_en = 1'b0;
    if (idx < NPIX) begin mdl_r[idx] = r; mdl_g[idx] = g; mdl_b[idx] = b; end
  endtask

  task automatic request(output int rcyc);
    bus.frame_req = 1'b1;
    rcyc = cyc;
    tick();
    bus.frame_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.wr_en = 0; bus.frame_req = 0; bus.nc_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    rst_cyc = cyc;
    model_clear();
    clear_frame();
  endtask

  function automatic int first_ld();
    return (ld_q.size() > 0) ? ld_q[0].c : -1000;
  endfunction

  // Controller model: serves loads (optionally stalling before pixel stall_at, writing
  // during the stall), drops ready after go for low_cycles, then raises it again.
  task automatic serve_frame(input int low_cycles, input int stall_at, input int stall_len, input bit req_in_send);
    int  n, rise;
    bit  stalled;
    logic [7:0] v;
    n = 0; stalled = 0;
    while (go_cnt == 0 && n < 600) begin
      tick(); n++;
      if (stall_at > 0 && !stalled && ld_q.size() == stall_at) begin
        stalled = 1; bus.nc_ready = 1'b0;
        v = 8'($urandom_range(1, 255));
        write_px(NPIX - 1, v, ~v, 8'h5A);
        exp_r[NPIX-1] = v; exp_g[NPIX-1] = ~v; exp_b[NPIX-1] = 8'h5A;
        write_px(1, 8'($urandom), 8'($urandom), 8'($urandom));
        repeat (stall_len - 2) tick();
        bus.nc_ready = 1'b1;
      end
    end
    chk("go_seen", 32'(go_cnt != 0), 32'd1);
    bus.nc_ready = 1'b0;
    if (req_in_send) bus.frame_req = 1'b1;
    tick();
    bus.frame_req = 1'b0;
    repeat (low_cycles - 1) tick();
    bus.nc_ready = 1'b1;
    rise = cyc; n = 0;
    while (done_cnt == 0 && n < 50) begin tick(); n++; end
    chk("done_latency", 32'(done_cyc - rise), 32'd2);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, ":nload"}, 32'(ld_q.size()), 32'(NPIX));
    for (int i = 0; i < ld_q.size() && i < NPIX; i++) begin
      chk($sformatf("%s:pix%0d_idx", tag, i), 32'(ld_q[i].pix), 32'(i));
      chk($sformatf("%s:pix%0d_rgb", tag, i), 32'({ld_q[i].r, ld_q[i].g, ld_q[i].b}),
          32'({8'(exp_r[i] >> shv), 8'(exp_g[i] >> shv), 8'(exp_b[i] >> shv)}));
    end
    chk({tag, ":go_cnt"}, 32'(go_cnt), 32'd1);
    if (ld_q.size() > 0) chk({tag, ":go_after_load"}, 32'(go_cyc > ld_q[ld_q.size()-1].c), 32'd1);
    chk({tag, ":done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, ":busy_low"}, 32'(busy_low), 32'd0);
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_pixel = 0; bus.wr_red = 0; bus.wr_green = 0; bus.wr_blue = 0;
    bus.frame_req = 0; bus.nc_ready = 1'b1;
`ifdef NEO_BRIGHTNESS_EN
    bus.bright_shift = 2'd0;
`endif
    reset = 1'b0;
    #1 reset = 1'b1;
    do_reset();
    chk("reset_outputs", 32'({bus.nc_load, bus.nc_go, bus.busy, bus.frame_done, bus.nc_pixel,
                              bus.nc_red, bus.nc_green, bus.nc_blue}), 32'd0);

    // Single red pixel; writes past NUM_PIXELS ignored; long SEND phase.
    write_px(3, 8'd250, 8'd0, 8'd0);
    write_px(6, 8'hFF, 8'hFF, 8'hFF);
    write_px(7, 8'h11, 8'h22, 8'h33);
    snap(); clear_frame();
    request(rc);
    serve_frame(100, 0, 0, 0);
    check_frame("t1");
    chk("t1_latency", 32'(first_ld() - rc), 32'd3);
    if (ld_q.size() > 3) chk("t1_px3", 32'({ld_q[3].r, ld_q[3].g, ld_q[3].b}), 32'h00FA0000);
    chk("t1_busy_at_done", 32'(bus.busy), 32'd0);
    repeat (3) tick();
    chk("t1_idle_after", 32'({bus.busy, bus.frame_done, bus.nc_load}), 32'd0);

    // Merged requests while waiting for ready, then back-to-back frame from a mid-frame request.
    do_reset();
    for (int i = 0; i < NPIX; i++) write_px(i, 8'($urandom), 8'($urandom), 8'($urandom));
    bus.nc_ready = 1'b0;
    bus.frame_req = 1'b1;
    repeat (3) tick();
    bus.frame_req = 1'b0;
    repeat (2) tick();
    chk("merge_wait_ready", 32'(bus.busy), 32'd0);
    snap(); clear_frame();
    bus.nc_ready = 1'b1;
    serve_frame(5, 0, 0, 1);
    check_frame("m1");
    d = done_cyc;
    snap(); clear_frame();
    serve_frame(5, 0, 0, 0);
    check_frame("m2");
    chk("b2b_start", 32'(first_ld() - d), 32'd2);
    clear_frame();
    repeat (10) tick();
    chk("no_dup_frame", 32'(ld_q.size() + go_cnt), 32'd0);

    // Ready stall before pixel 4, with writes to an unloaded and an already-loaded pixel.
    do_reset();
    for (int i = 0; i < NPIX; i++) write_px(i, 8'($urandom), 8'($urandom), 8'($urandom));
    snap(); clear_frame();
    request(rc);
    serve_frame(5, 4, 10, 0);
    check_frame("t4");
    if (ld_q.size() > 4) chk("t4_stall_gap", 32'(ld_q[4].c - ld_q[3].c), 32'd11);
    snap(); clear_frame();
    request(rc);
    serve_frame(5, 0, 0, 0);
    check_frame("t4_next");

    // Reset during SEND clears outputs immediately and the buffer for the next frame.
    do_reset();
    write_px(5, 8'($urandom_range(1, 255)), 8'h80, 8'h01);
    write_px(2, 8'h40, 8'($urandom_range(1, 255)), 8'h02);
    clear_frame();
    request(rc);
    for (int n = 0; n < 100 && go_cnt == 0; n++) tick();
    chk("t5_go_seen", 32'(go_cnt), 32'd1);
    bus.nc_ready = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("t5_reset_outputs", 32'({bus.nc_load, bus.nc_go, bus.busy, bus.frame_done, bus.nc_pixel,
                                 bus.nc_red, bus.nc_green, bus.nc_blue}), 32'd0);
    tick();
    reset = 1'b0;
    rst_cyc = cyc;
    model_clear();
    bus.nc_ready = 1'b1;
    snap(); clear_frame();
    request(rc);
    serve_frame(5, 0, 0, 0);
    check_frame("t5");

`ifdef NEO_BRIGHTNESS_EN
    do_reset();
    bus.bright_shift = 2'd2; shv = 2;
    write_px(0, 8'd250, 8'd128, 8'd4);
    write_px(1, 8'($urandom), 8'($urandom), 8'($urandom));
    snap(); clear_frame();
    request(rc);
    serve_frame(5, 0, 0, 0);
    check_frame("t6");
    if (ld_q.size() > 0) chk("t6_px0", 32'({ld_q[0].r, ld_q[0].g, ld_q[0].b}), 32'h003E2001);
    bus.bright_shift = 2'd0; shv = 0;
`endif

    // Timer-driven refresh only: one frame per period, none lost or duplicated.
    do_reset();
    for (int f = 1; f <= 5; f++) begin
      repeat (4) write_px(int'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom));
      snap(); clear_frame();
      serve_frame(5, 0, 0, 0);
      check_frame($sformatf("t3_f%0d", f));
      chk($sformatf("t3_f%0d_start", f), 32'(first_ld() - rst_cyc), 32'(RCYC * f + 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
